// File: rtl/raster_pkg.sv
// raster_pkg: shared state encoding, octant table and clip helper for the raster blocks
package raster_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_TEST, S_PLOT, S_STEP, S_DONE
`ifdef CIRCLE_FILL_EN
    , S_SPAN
`endif
  } raster_state_t;
  // Entry k occupies bits [3k+2:3k] as {sx, sy, swap}; sx/sy set means subtract
  localparam logic [23:0] OCT_TBL = {3'b011, 3'b010, 3'b111, 3'b110,
                                     3'b101, 3'b100, 3'b001, 3'b000};
  function automatic logic on_screen(input logic signed [31:0] px, input logic signed [31:0] py,
                                     input int w, input int h);
    return px >= 0 && px < w && py >= 0 && py < h;
  endfunction
endpackage

// File: rtl/raster_clip.sv
// raster_clip: combinational on-screen test gating a pixel write
module raster_clip
  import raster_pkg::*;
#(
  parameter int CW = 11,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
)(
  input  logic signed [CW-1:0] px,
  input  logic signed [CW-1:0] py,
  input  logic                 en,
  output logic                 plot
);
  assign plot = en && on_screen(32'(px), 32'(py), SCREEN_W, SCREEN_H);
endmodule

// File: rtl/circle_raster.sv
// circle_raster: midpoint circle rasteriser with octant mask and clipping.
// Define CIRCLE_FILL_EN to add the fill port and horizontal-span filled-disc mode.
module circle_raster
  import raster_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int R_W = 8,
  parameter int COLOUR_W = 3
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                ready,
  input  logic [X_W-1:0]      centre_x,
  input  logic [Y_W-1:0]      centre_y,
  input  logic [R_W-1:0]      radius,
  input  logic [COLOUR_W-1:0] colour,
  input  logic [7:0]          octant_en,
`ifdef CIRCLE_FILL_EN
  input  logic                fill,
`endif
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);
  localparam int MW = X_W > Y_W ? X_W : Y_W;
  localparam int CW = (MW > R_W ? MW : R_W) + 3;
  localparam logic signed [CW-1:0] ONE = CW'(1);
  localparam logic signed [CW-1:0] THREE = CW'(3);
  localparam logic signed [CW-1:0] FIVE = CW'(5);
  raster_state_t state, nxt, first;
  logic signed [CW-1:0] x, y, crit, cx, cy, a, b, px, py;
  logic [7:0] oct_en;
  logic [2:0] k, oct;
  logic en, plot_ok;
`ifdef CIRCLE_FILL_EN
  logic fill_r;
  logic [1:0] s;
  logic signed [CW-1:0] sp_x, span_end;
  assign first = fill_r ? S_SPAN : S_PLOT;
  assign span_end = s[1] ? cx + y : cx + x;
`else
  assign first = S_PLOT;
`endif
  assign oct = OCT_TBL[3*k +: 3];
  assign a = oct[0] ? y : x;
  assign b = oct[0] ? x : y;
  always_comb begin
    px = oct[2] ? cx - a : cx + a;
    py = oct[1] ? cy - b : cy + b;
    en = state == S_PLOT && oct_en[k];
`ifdef CIRCLE_FILL_EN
    if (state == S_SPAN) begin
      px = sp_x;
      py = s[0] ? cy - (s[1] ? x : y) : cy + (s[1] ? x : y);
      en = 1'b1;
    end
`endif
  end
  raster_clip #(.CW(CW), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_clip (
    .px(px), .py(py), .en(en), .plot(plot_ok)
  );
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: nxt = start && ready ? S_INIT : S_IDLE;
      S_INIT: nxt = S_TEST;
      S_TEST: nxt = y > x ? S_DONE : first;
      S_PLOT: nxt = k == 3'd7 ? S_STEP : S_PLOT;
`ifdef CIRCLE_FILL_EN
      S_SPAN: nxt = s == 2'd3 && sp_x == span_end ? S_STEP : S_SPAN;
`endif
      S_STEP: nxt = S_TEST;
      S_DONE: nxt = start ? S_DONE : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ready <= 1'b0;
      done <= 1'b0;
      vga_plot <= 1'b0;
      vga_x <= '0;
      vga_y <= '0;
      vga_colour <= '0;
      x <= '0;
      y <= '0;
      crit <= '0;
      cx <= '0;
      cy <= '0;
      oct_en <= '0;
      k <= '0;
`ifdef CIRCLE_FILL_EN
      fill_r <= 1'b0;
      s <= '0;
      sp_x <= '0;
`endif
    end else begin
      state <= nxt;
      ready <= nxt == S_IDLE;
      done <= nxt == S_DONE;
      vga_plot <= plot_ok;
      vga_x <= px[X_W-1:0];
      vga_y <= py[Y_W-1:0];
      case (state)
        S_IDLE: if (start && ready) begin
          cx <= CW'(centre_x);
          cy <= CW'(centre_y);
          x <= CW'(radius);
          vga_colour <= colour;
          oct_en <= octant_en;
`ifdef CIRCLE_FILL_EN
          fill_r <= fill;
`endif
        end
        S_INIT: begin
          y <= '0;
          crit <= ONE - x;
        end
        S_TEST: begin
          k <= '0;
`ifdef CIRCLE_FILL_EN
          s <= '0;
          sp_x <= cx - x;
`endif
        end
        S_PLOT: k <= k + 3'd1;
`ifdef CIRCLE_FILL_EN
        S_SPAN: if (sp_x == span_end) begin
          s <= s + 2'd1;
          sp_x <= s == 2'd0 ? cx - x : cx - y;
        end else sp_x <= sp_x + ONE;
`endif
        S_STEP: begin
          y <= y + ONE;
          if (crit[CW-1] || crit == '0) crit <= crit + (y <<< 1) + THREE;
          else begin
            x <= x - ONE;
            crit <= crit + ((y - x) <<< 1) + FIVE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_circle_raster.sv
// tb_circle_raster: table, random and reset checks of circle_raster against an integer reference model
module tb_circle_raster;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic ready, done, vga_plot;
  logic [7:0] centre_x = '0, radius = '0, octant_en = '0, vga_x;
  logic [6:0] centre_y = '0, vga_y;
  logic [2:0] colour = '0, vga_colour;
`ifdef CIRCLE_FILL_EN
  logic fill = 1'b0;
`endif
  int tests = 0, fails = 0;
  typedef struct {int x; int y;} pix_t;
  typedef struct {int cx; int cy; int r; logic [7:0] m; int n_exp;} vec_t;
  pix_t exp_q[$], got_q[$];
  vec_t vt[6];

  circle_raster dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius), .colour(colour),
    .octant_en(octant_en),
`ifdef CIRCLE_FILL_EN
    .fill(fill),
`endif
    .done(done), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Midpoint circle in plain integers: every octant point of every iteration, masked and clipped
  function automatic void model(input int cx, input int cy, input int r, input logic [7:0] m);
    int x = r, y = 0, d = 1 - r;
    int px[8], py[8];
    exp_q.delete();
    while (y <= x) begin
      px = '{cx + x, cx + y, cx - x, cx - y, cx - x, cx - y, cx + x, cx + y};
      py = '{cy + y, cy + x, cy + y, cy + x, cy - y, cy - x, cy - y, cy - x};
      for (int i = 0; i < 8; i++)
        if (m[i] && px[i] >= 0 && px[i] < 160 && py[i] >= 0 && py[i] < 120)
          exp_q.push_back('{px[i], py[i]});
      y++;
      if (d <= 0) d += 2 * y + 1;
      else begin
        x--;
        d += 2 * (y - x) + 1;
      end
    end
  endfunction

  task automatic run(input int cx, input int cy, input int r, input logic [7:0] m,
                     input logic f, input logic [2:0] col);
    int n = 0, colbad = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_start", int'(ready), 1);
    centre_x = 8'(cx);
    centre_y = 7'(cy);
    radius = 8'(r);
    octant_en = m;
    colour = col;
`ifdef CIRCLE_FILL_EN
    fill = f;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    centre_x = 8'($urandom);
    centre_y = 7'($urandom);
    radius = 8'($urandom);
    octant_en = 8'($urandom);
    colour = 3'($urandom);
`ifdef CIRCLE_FILL_EN
    fill = 1'($urandom);
`endif
    got_q.delete();
    n = 0;
    while (!done && n < 3000) begin
      if (vga_plot) begin
        got_q.push_back('{int'(vga_x), int'(vga_y)});
        if (vga_colour != col) colbad++;
      end
      @(negedge clk);
      n++;
    end
    check("done_reached", int'(done), 1);
    check("colour_held", colbad, 0);
    @(negedge clk);
    check("ready_after_done", int'(ready), 1);
    if (!f) begin
      model(cx, cy, r, m);
      check($sformatf("plot_count c=(%0d,%0d) r=%0d m=%02h", cx, cy, r, m), got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        check($sformatf("pix%0d_x r=%0d", i, r), got_q[i].x, exp_q[i].x);
        check($sformatf("pix%0d_y r=%0d", i, r), got_q[i].y, exp_q[i].y);
      end
    end
  endtask

  initial begin
    int bad, n;
    pix_t r1[8];
    vt[0] = '{80, 60, 0, 8'hFF, 8};
    vt[1] = '{80, 60, 1, 8'hFF, 16};
    vt[2] = '{80, 60, 1, 8'h00, 0};
    vt[3] = '{80, 60, 1, 8'h01, 2};
    vt[4] = '{0, 0, 10, 8'hFF, -1};
    vt[5] = '{80, 60, 20, 8'h01, -1};
    r1 = '{'{81, 60}, '{80, 61}, '{79, 60}, '{80, 61}, '{79, 60}, '{80, 59}, '{81, 60}, '{80, 59}};
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", int'(ready), 0);
    check("rst_done", int'(done), 0);
    check("rst_plot", int'(vga_plot), 0);
    check("rst_xy", int'(vga_x) + int'(vga_y), 0);
    check("rst_colour", int'(vga_colour), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_first_clk", int'(ready), 0);
    @(negedge clk);
    check("ready_after_first_clk", int'(ready), 1);

    for (int i = 0; i < 6; i++) begin
      run(vt[i].cx, vt[i].cy, vt[i].r, vt[i].m, 1'b0, 3'(i + 1));
      if (vt[i].n_exp >= 0) check($sformatf("vec%0d_count", i), got_q.size(), vt[i].n_exp);
      if (i == 0) begin
        bad = 0;
        foreach (got_q[j]) if (got_q[j].x != 80 || got_q[j].y != 60) bad++;
        check("r0_all_centre", bad, 0);
      end
      if (i == 1 && got_q.size() == 16) begin
        bad = 0;
        for (int j = 0; j < 8; j++) if (got_q[j].x != r1[j].x || got_q[j].y != r1[j].y) bad++;
        for (int j = 8; j < 16; j++)
          if ((got_q[j].x != 79 && got_q[j].x != 81) || (got_q[j].y != 59 && got_q[j].y != 61)) bad++;
        check("r1_hand_sequence", bad, 0);
      end
      if (i == 4) begin
        bad = 0;
        foreach (got_q[j]) if (got_q[j].x > 10 || got_q[j].y > 10) bad++;
        check("corner_clip", bad, 0);
        check("corner_nonempty", int'(got_q.size() > 0), 1);
      end
      if (i == 5) begin
        bad = 0;
        foreach (got_q[j])
          if (got_q[j].y < 60 || got_q[j].x - 80 < got_q[j].y - 60) bad++;
        check("octant0_wedge", bad, 0);
      end
    end

    for (int i = 0; i < 20; i++)
      run($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 60),
          8'($urandom), 3'($urandom), 1'b0);

    // Abort a large circle mid-PLOT with an asynchronous reset
    @(negedge clk);
    centre_x = 8'd80;
    centre_y = 7'd60;
    radius = 8'd50;
    octant_en = 8'hFF;
    colour = 3'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!vga_plot && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("plot_before_abort", int'(vga_plot), 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_plot", int'(vga_plot), 0);
    check("abort_ready", int'(ready), 0);
    check("abort_done", int'(done), 0);
    check("abort_xy", int'(vga_x) + int'(vga_y), 0);
    check("abort_colour", int'(vga_colour), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (vga_plot) bad++;
    end
    check("no_plot_after_abort", bad, 0);
    check("ready_after_abort", int'(ready), 1);
    run(80, 60, 1, 8'hFF, 1'b0, 3'd2);
    check("restart_count", got_q.size(), 16);

`ifdef CIRCLE_FILL_EN
    run(80, 60, 2, 8'h00, 1'b1, 3'd5);
    bad = 0;
    foreach (got_q[j]) if (got_q[j].x < 78 || got_q[j].x > 82 || got_q[j].y < 58 || got_q[j].y > 62) bad++;
    check("fill_bounds", bad, 0);
    for (int dy = -2; dy <= 2; dy++)
      for (int dx = -2; dx <= 2; dx++)
        if (dx * dx + dy * dy <= 4) begin
          int hit = 0;
          foreach (got_q[j]) if (got_q[j].x == 80 + dx && got_q[j].y == 60 + dy) hit = 1;
          check($sformatf("fill_cover(%0d,%0d)", dx, dy), hit, 1);
        end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
